debounce_edge: RTL

- Sits directly downstream of the bit synchroniser.
- Consumes an already-synchronised single bit from a mechanical switch or noisy line and produces a debounced level plus one-cycle rising/falling edge pulses for control logic (counters, FSM triggers).
- Rejects glitches shorter than a parameterised number of clock cycles.

---
 rtl/debounce_pkg.sv | 11 +
 rtl/debounce_edge_hold_timer.sv | 35 +++
 rtl/debounce_edge.sv | 87 ++++++++
 3 files changed

// File: rtl/debounce_pkg.sv
// rtl/debounce_pkg.sv - shared state type and counter width helper for debounce_edge
package debounce_pkg;

  typedef enum logic {ST_STABLE, ST_CHANGING} t_debounce_state;

  // Bits needed to hold values 0..max_val; never less than one bit.
  function automatic int cnt_width(input int max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/debounce_edge_hold_timer.sv
// rtl/debounce_edge_hold_timer.sv - saturating long-press counter with a single-shot pulse
module hold_timer
  import debounce_pkg::*;
#(
  parameter int LONG_CYCLES = 1024
) (
  input  logic clk,
  input  logic rst_n,
  input  logic level,
  output logic pulse
);

  localparam int HW = cnt_width(LONG_CYCLES);
  localparam logic [HW-1:0] HOLD_MAX = HW'(LONG_CYCLES);

  logic [HW-1:0] cnt;

  // level is the value the debounced output takes on this edge, so the
  // out_rise cycle already sees cnt == 1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt   <= '0;
      pulse <= 1'b0;
    end else begin
      pulse <= 1'b0;
      if (!level) begin
        cnt <= '0;
      end else if (cnt != HOLD_MAX) begin
        cnt   <= cnt + HW'(1);
        pulse <= (cnt == HOLD_MAX - HW'(1));
      end
    end
  end

endmodule

// File: rtl/debounce_edge.sv
// rtl/debounce_edge.sv - glitch-rejecting debouncer with edge pulses
// Optional long-press pulse enabled by defining DEBOUNCE_LONGPRESS_EN.
module debounce_edge
  import debounce_pkg::*;
#(
  parameter int   STABLE_CYCLES = 16,
  parameter int   LONG_CYCLES   = 1024,
  parameter logic INIT_LEVEL    = 1'b0
) (
  input  logic in_clk,
  input  logic in_rst,
  input  logic in_bit,
  output logic out_level,
  output logic out_rise,
  output logic out_fall,
  output logic out_long
);

  localparam int CW = cnt_width(STABLE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_CYCLES - 1);

  t_debounce_state state;
  logic [CW-1:0]   cnt;
  logic            flip;
  logic            level_next;

  always_comb begin
    flip = 1'b0;
    if (in_bit != out_level) begin
      if (state == ST_STABLE) flip = (STABLE_CYCLES == 1);
      else                    flip = (cnt == CNT_LAST);
    end
    level_next = flip ? ~out_level : out_level;
  end

  always_ff @(posedge in_clk or negedge in_rst) begin
    if (!in_rst) begin
      state     <= ST_STABLE;
      cnt       <= '0;
      out_level <= INIT_LEVEL;
      out_rise  <= 1'b0;
      out_fall  <= 1'b0;
    end else begin
      out_level <= level_next;
      out_rise  <= flip & ~out_level;
      out_fall  <= flip & out_level;
      case (state)
        ST_STABLE: begin
          if (in_bit != out_level && !flip) begin
            state <= ST_CHANGING;
            cnt   <= CW'(1);
          end else begin
            cnt <= '0;
          end
        end
        ST_CHANGING: begin
          // Either the input fell back (glitch) or the count completed.
          if (in_bit == out_level || flip) begin
            state <= ST_STABLE;
            cnt   <= '0;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        default: begin
          state <= ST_STABLE;
          cnt   <= '0;
        end
      endcase
    end
  end

`ifdef DEBOUNCE_LONGPRESS_EN
  hold_timer #(
    .LONG_CYCLES(LONG_CYCLES)
  ) u_hold_timer (
    .clk  (in_clk),
    .rst_n(in_rst),
    .level(level_next),
    .pulse(out_long)
  );
`else
  // LONG_CYCLES only matters when the hold timer is built.
  assign out_long = 1'b0 & (LONG_CYCLES < 1);
`endif

endmodule
